// File: rtl/parking_lot_manager.sv
// rtl/parking_lot_manager.sv - two-barrier parking lot controller with occupancy tracking
//
// Purpose: drives an entry and an exit barrier from upstream grant and
// barrier-sensor inputs, and keeps a saturating count of vehicles inside.
// Each barrier is its own CLOSED/OPEN FSM with an open timeout. The two FSMs
// interact only through the occupancy count.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   entry_grant  entry authorised (rising edge is the event)
//   exit_grant   exit authorised (rising edge is the event)
//   entry_pass   vehicle crossed the entry sensor (rising edge is the event)
//   exit_pass    vehicle crossed the exit sensor (rising edge is the event)
//   entry_open   entry barrier drive, 1 = open
//   exit_open    exit barrier drive, 1 = open
//   occupancy    vehicles currently inside
//   lot_full     occupancy == CAPACITY
//   lot_empty    occupancy == 0
//   entry_reject one-cycle pulse: entry grant refused because the lot is full
//   timeout      one-cycle pulse per barrier closed without a pass
//                (bit0 = entry, bit1 = exit)
module parking_lot_manager #(
  parameter int unsigned CAPACITY    = 8,
  parameter int unsigned OPEN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       entry_grant,
  input  logic       exit_grant,
  input  logic       entry_pass,
  input  logic       exit_pass,
  output logic       entry_open,
  output logic       exit_open,
  output logic [3:0] occupancy,
  output logic       lot_full,
  output logic       lot_empty,
  output logic       entry_reject,
  output logic [1:0] timeout
);

  localparam logic [3:0] CAP_VAL   = 4'(CAPACITY);
  localparam logic [7:0] TIMER_MAX = 8'(OPEN_CYCLES - 1);

  typedef enum logic {
    CLOSED = 1'b0,
    OPEN   = 1'b1
  } barrier_state_t;

  // Input sampling: one register stage, plus the previous sample for edge detection.
  logic [3:0] in_q;
  logic [3:0] in_prev;
  logic [3:0] in_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q    <= 4'b0000;
      in_prev <= 4'b0000;
    end else begin
      in_q    <= {exit_pass, entry_pass, exit_grant, entry_grant};
      in_prev <= in_q;
    end
  end

  assign in_edge = in_q & ~in_prev;

  logic entry_grant_edge;
  logic exit_grant_edge;
  logic entry_pass_edge;
  logic exit_pass_edge;

  assign entry_grant_edge = in_edge[0];
  assign exit_grant_edge  = in_edge[1];
  assign entry_pass_edge  = in_edge[2];
  assign exit_pass_edge   = in_edge[3];

  barrier_state_t entry_state, entry_state_next;
  barrier_state_t exit_state,  exit_state_next;
  logic [7:0]     entry_timer, entry_timer_next;
  logic [7:0]     exit_timer,  exit_timer_next;
  logic           entry_reject_next;
  logic [1:0]     timeout_next;
  logic [3:0]     occupancy_next;

  // State register: FSMs, timers, count and the registered pulse outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry_state  <= CLOSED;
      exit_state   <= CLOSED;
      entry_timer  <= 8'd0;
      exit_timer   <= 8'd0;
      occupancy    <= 4'd0;
      entry_reject <= 1'b0;
      timeout      <= 2'b00;
    end else begin
      entry_state  <= entry_state_next;
      exit_state   <= exit_state_next;
      entry_timer  <= entry_timer_next;
      exit_timer   <= exit_timer_next;
      occupancy    <= occupancy_next;
      entry_reject <= entry_reject_next;
      timeout      <= timeout_next;
    end
  end

  // Entry barrier next-state logic. A full lot turns a grant into a reject pulse.
  always_comb begin
    entry_state_next  = entry_state;
    entry_timer_next  = entry_timer;
    entry_reject_next = 1'b0;
    timeout_next[0]   = 1'b0;
    case (entry_state)
      CLOSED: begin
        entry_timer_next = 8'd0;
        if (entry_grant_edge) begin
          if (lot_full) entry_reject_next = 1'b1;
          else          entry_state_next  = OPEN;
        end
      end
      OPEN: begin
        // A pass edge beats a simultaneous timer expiry.
        if (entry_pass_edge) begin
          entry_state_next = CLOSED;
          entry_timer_next = 8'd0;
        end else if (entry_timer == TIMER_MAX) begin
          entry_state_next = CLOSED;
          entry_timer_next = 8'd0;
          timeout_next[0]  = 1'b1;
        end else begin
          entry_timer_next = entry_timer + 8'd1;
        end
      end
      default: entry_state_next = CLOSED;
    endcase
  end

  // Exit barrier next-state logic; not gated by lot_empty (count saturates instead).
  always_comb begin
    exit_state_next = exit_state;
    exit_timer_next = exit_timer;
    timeout_next[1] = 1'b0;
    case (exit_state)
      CLOSED: begin
        exit_timer_next = 8'd0;
        if (exit_grant_edge) exit_state_next = OPEN;
      end
      OPEN: begin
        if (exit_pass_edge) begin
          exit_state_next = CLOSED;
          exit_timer_next = 8'd0;
        end else if (exit_timer == TIMER_MAX) begin
          exit_state_next = CLOSED;
          exit_timer_next = 8'd0;
          timeout_next[1] = 1'b1;
        end else begin
          exit_timer_next = exit_timer + 8'd1;
        end
      end
      default: exit_state_next = CLOSED;
    endcase
  end

  // Occupancy: only passes through an open barrier count; simultaneous
  // entry and exit cancel out; the count saturates at both ends.
  logic entry_done;
  logic exit_done;

  assign entry_done = (entry_state == OPEN) && entry_pass_edge;
  assign exit_done  = (exit_state == OPEN) && exit_pass_edge;

  always_comb begin
    occupancy_next = occupancy;
    if (entry_done && !exit_done) begin
      if (occupancy < CAP_VAL) occupancy_next = occupancy + 4'd1;
    end else if (exit_done && !entry_done) begin
      if (occupancy != 4'd0) occupancy_next = occupancy - 4'd1;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    entry_open = (entry_state == OPEN);
    exit_open  = (exit_state == OPEN);
    lot_full   = (occupancy == CAP_VAL);
    lot_empty  = (occupancy == 4'd0);
  end

endmodule

// File: tb/tb_parking_lot_manager.sv
// tb/tb_parking_lot_manager.sv - directed table-driven bench for parking_lot_manager
module tb_parking_lot_manager;

  logic       clk;
  logic       reset_n;
  logic       entry_grant;
  logic       exit_grant;
  logic       entry_pass;
  logic       exit_pass;
  logic       entry_open;
  logic       exit_open;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       lot_empty;
  logic       entry_reject;
  logic [1:0] timeout;

  parking_lot_manager #(
    .CAPACITY    (4),
    .OPEN_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .entry_grant  (entry_grant),
    .exit_grant   (exit_grant),
    .entry_pass   (entry_pass),
    .exit_pass    (exit_pass),
    .entry_open   (entry_open),
    .exit_open    (exit_open),
    .occupancy    (occupancy),
    .lot_full     (lot_full),
    .lot_empty    (lot_empty),
    .entry_reject (entry_reject),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs applied in a row show their effect on the outputs two rows later.
  typedef struct {
    logic eg;
    logic xg;
    logic ep;
    logic xp;
    logic eo;
    logic xo;
    int   occ;
    logic rej;
    int   to;
  } vec_t;

  vec_t tbl[$];
  int   total_checks  = 0;
  int   passed_checks = 0;

  task automatic check(input string name, input int act, input int exp);
    total_checks++;
    if (act == exp) passed_checks++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic eg, input logic xg, input logic ep, input logic xp,
                     input logic eo, input logic xo, input int occ, input logic rej,
                     input int to);
    vec_t v;
    v.eg = eg; v.xg = xg; v.ep = ep; v.xp = xp;
    v.eo = eo; v.xo = xo; v.occ = occ; v.rej = rej; v.to = to;
    tbl.push_back(v);
  endtask

  // Grant in one row, pass in the next: barrier open for one row, count changes the row after.
  task automatic add_entry(input int occ);
    add(1, 0, 0, 0, 0, 0, occ,     0, 0);
    add(0, 0, 1, 0, 0, 0, occ,     0, 0);
    add(0, 0, 0, 0, 1, 0, occ,     0, 0);
    add(0, 0, 0, 0, 0, 0, occ + 1, 0, 0);
  endtask

  task automatic add_exit(input int occ);
    add(0, 1, 0, 0, 0, 0, occ,     0, 0);
    add(0, 0, 0, 1, 0, 0, occ,     0, 0);
    add(0, 0, 0, 0, 0, 1, occ,     0, 0);
    add(0, 0, 0, 0, 0, 0, occ - 1, 0, 0);
  endtask

  task automatic do_exit();
    tick(); exit_grant = 1'b1;
    tick(); exit_grant = 1'b0; exit_pass = 1'b1;
    tick(); exit_pass  = 1'b0;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    entry_grant = 1'b0;
    exit_grant  = 1'b0;
    entry_pass  = 1'b0;
    exit_pass   = 1'b0;

    // Normal entry: open three rows, then occupancy 0 -> 1.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Fill to capacity, then a refused grant.
    for (int k = 1; k <= 3; k++) add_entry(k);
    add(1, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 1, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    // Two exits down to 2, then an exit timeout.
    add_exit(4);
    add_exit(3);
    add(0, 1, 0, 0, 0, 0, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 0, 1, 2, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2, 0, 2);
    add(0, 0, 0, 0, 0, 0, 2, 0, 0);
    // Up to 3, then both barriers open and both pass in the same cycle.
    add_entry(2);
    add(1, 1, 0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 1, 1, 3, 0, 0);
    add(0, 0, 1, 1, 1, 1, 3, 0, 0);
    add(0, 0, 0, 0, 1, 1, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);
    // Entry pass edge in the same cycle as timer expiry: counts, no timeout.
    add(1, 0, 0, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);
    for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    add(0, 0, 1, 0, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 1, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    // Pass edges with both barriers closed are ignored.
    add(0, 0, 1, 1, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0);

    // Reset state, observed while reset is held.
    tick(); tick();
    check("reset entry_open", entry_open, 0);
    check("reset exit_open", exit_open, 0);
    check("reset occupancy", occupancy, 0);
    check("reset lot_empty", lot_empty, 1);
    check("reset lot_full", lot_full, 0);
    check("reset entry_reject", entry_reject, 0);
    check("reset timeout", timeout, 0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      tick();
      check($sformatf("row%0d entry_open", i), entry_open, tbl[i].eo);
      check($sformatf("row%0d exit_open", i), exit_open, tbl[i].xo);
      check($sformatf("row%0d occupancy", i), occupancy, tbl[i].occ);
      check($sformatf("row%0d lot_full", i), lot_full, (tbl[i].occ == 4) ? 1 : 0);
      check($sformatf("row%0d lot_empty", i), lot_empty, (tbl[i].occ == 0) ? 1 : 0);
      check($sformatf("row%0d entry_reject", i), entry_reject, tbl[i].rej);
      check($sformatf("row%0d timeout", i), timeout, tbl[i].to);
      entry_grant = tbl[i].eg;
      exit_grant  = tbl[i].xg;
      entry_pass  = tbl[i].ep;
      exit_pass   = tbl[i].xp;
    end

    // Reset while the entry barrier is open at occupancy 2.
    do_exit();
    do_exit();
    check("pre-reset occupancy", occupancy, 2);
    tick(); entry_grant = 1'b1;
    tick(); entry_grant = 1'b0;
    tick();
    check("pre-reset entry_open", entry_open, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset entry_open", entry_open, 0);
    check("async reset occupancy", occupancy, 0);
    check("async reset lot_empty", lot_empty, 1);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post-reset pulses %0d", k), {entry_reject, timeout}, 0);
      check($sformatf("post-reset entry_open %0d", k), entry_open, 0);
    end

    // Exit pass at occupancy 0: barrier still opens, count stays 0.
    tick(); exit_grant = 1'b1;
    tick(); exit_grant = 1'b0; exit_pass = 1'b1;
    tick(); exit_pass  = 1'b0;
    check("exit at zero exit_open", exit_open, 1);
    tick();
    check("exit at zero closed", exit_open, 0);
    check("exit at zero occupancy", occupancy, 0);
    check("exit at zero lot_empty", lot_empty, 1);

    // Grant held high across reset release registers as an edge.
    reset_n = 1'b0;
    entry_grant = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    check("held grant one cycle after release", entry_open, 0);
    tick();
    check("held grant opens barrier", entry_open, 1);
    entry_grant = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/parking_lot_manager.md
PARKING_LOT_MANAGER -- requirements
Module: parking_lot_manager

Interface
REQ-001 Parameter CAPACITY, default 8: maximum vehicles admitted, range 1..15.
REQ-002 Parameter OPEN_CYCLES, default 16: barrier open timeout in clk cycles, range 2..255.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 entry_grant  input  1  entry authorised by the upstream gate controller; level signal, rising edge is the event.
REQ-006 exit_grant  input  1  exit authorised; level signal, rising edge is the event.
REQ-007 entry_pass  input  1  vehicle crossed the entry barrier sensor; rising edge is the event.
REQ-008 exit_pass  input  1  vehicle crossed the exit barrier sensor; rising edge is the event.
REQ-009 entry_open  output  1  entry barrier drive, 1 = open.
REQ-010 exit_open  output  1  exit barrier drive, 1 = open.
REQ-011 occupancy  output  4  vehicles currently inside.
REQ-012 lot_full  output  1  occupancy == CAPACITY.
REQ-013 lot_empty  output  1  occupancy == 0.
REQ-014 entry_reject  output  1  one-cycle pulse, entry grant refused because the lot is full.
REQ-015 timeout  output  2  one-cycle pulse per barrier closed without a pass; bit0 = entry, bit1 = exit.

Function
REQ-016 All four inputs SHALL be registered once; rising edge = current sample 1 AND previous sample 0.
REQ-017 Each barrier SHALL have an independent two-state FSM, CLOSED and OPEN, with an 8-bit timer.
REQ-018 Entry CLOSED->OPEN: entry_grant edge detected in cycle N with lot_full = 0; entry_open = 1 from cycle N+1; timer cleared.
REQ-019 Entry grant edge in CLOSED with lot_full = 1: entry_reject = 1 in cycle N+1 only; barrier stays CLOSED.
REQ-020 Exit CLOSED->OPEN: exit_grant edge in cycle N; exit_open = 1 from cycle N+1; not gated by lot_empty.
REQ-021 In OPEN the timer SHALL increment each cycle; grant edges SHALL be ignored; no reject pulse.
REQ-022 OPEN->CLOSED on pass edge: barrier closes the next cycle; occupancy updates in that same cycle.
REQ-023 OPEN->CLOSED on timeout: timer == OPEN_CYCLES-1 with no pass edge closes the barrier next cycle; the matching timeout bit pulses that cycle; occupancy unchanged.
REQ-024 Pass edge and timer expiry in the same cycle: pass wins; count updates; no timeout pulse.
REQ-025 Pass edges while the barrier is CLOSED SHALL be ignored; no count change.
REQ-026 Entry pass and exit pass in the same cycle: net occupancy change 0.
REQ-027 Occupancy SHALL saturate at 0 and CAPACITY; an exit pass at 0 leaves it at 0; an entry pass at CAPACITY leaves it at CAPACITY.
REQ-028 lot_full and lot_empty SHALL be decoded from the registered occupancy, so they track it with no added latency.
REQ-029 Both barriers OPEN simultaneously is legal; the FSMs SHALL not interact except through occupancy.

Reset
REQ-030 reset_n low SHALL asynchronously force the following: both FSMs CLOSED, timers 0, occupancy 0, entry_open/exit_open 0, entry_reject 0, timeout 2'b00, lot_empty 1, lot_full 0, input edge registers 0.
REQ-031 Reset asserted mid-operation SHALL close open barriers immediately and discard the count; no pulse outputs fire on deassertion.
REQ-032 A grant input held high across reset deassertion SHALL register as an edge one cycle after release.

Verification (CAPACITY=4, OPEN_CYCLES=8)
REQ-033 Normal entry: entry_grant edge, entry_pass edge 3 cycles later -> entry_open high 3 cycles, then low; occupancy 0->1; lot_empty falls.
REQ-034 Fill and reject: 4 complete entries, then a 5th grant -> occupancy 4, lot_full = 1, entry_reject pulses once, entry_open stays 0.
REQ-035 Timeout: exit_grant with occupancy 2 and no pass -> exit_open high 8 cycles, timeout = 2'b10 for one cycle, occupancy stays 2.
REQ-036 Simultaneous: both barriers open at occupancy 3; both pass edges in the same cycle -> occupancy stays 3, both barriers close the next cycle.
REQ-037 Boundary: exit pass at occupancy 0 -> occupancy 0. Pass edge coinciding with timer expiry -> count changes, timeout stays 0.
REQ-038 Reset mid-open: assert reset_n low while entry_open = 1 at occupancy 2 -> entry_open 0 and occupancy 0 immediately, before the next clk edge.
